// File: rtl/gtech_inbuf_filt.sv
// -----------------------------------------------------------------------------
// gtech_inbuf_filt
//
// Multi-channel pad input buffer.
//
// Each pad input passes through a SYNC_STAGES-deep synchroniser and then a
// persistence filter. A new level is accepted only after it has been seen on
// the synchroniser output for FILT_CYCLES consecutive cycles. Shorter
// excursions are discarded. Optional registered RISE/FALL pulses mark each
// accepted transition.
//
// Build option:
//   GTECH_INBUF_FILT_EDGE_EN  defined   -> RISE/FALL edge-detect flops built
//                             undefined -> RISE/FALL tied to 0, no flops
//
// Parameters:
//   WIDTH        number of independent channels (>=1)
//   SYNC_STAGES  synchroniser flops per channel (>=2)
//   FILT_CYCLES  persistence cycles needed to accept a new level (>=1)
//   RST_VAL      reset level of synchroniser flops and DATA_IN
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RST      in   synchronous reset, active-high
//   PAD_IN   in   [WIDTH] asynchronous pad levels
//   DATA_IN  out  [WIDTH] synchronised, filtered levels
//   RISE     out  [WIDTH] one-cycle pulse on accepted 0->1
//   FALL     out  [WIDTH] one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module gtech_inbuf_filt #(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PAD_IN,
  output logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  localparam int               CNT_W    = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;
  logic [CNT_W-1:0] cnt_p1  [WIDTH];
  logic [WIDTH-1:0] data_p1;
  logic [WIDTH-1:0] accept;

  // ---- Stage 0: synchroniser chain ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_p0[s] <= {WIDTH{RST_VAL}};
      end
    end else begin
      sync_p0[0] <= PAD_IN;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_p0[s] <= sync_p0[s-1];
      end
    end
  end

  assign sync_last = sync_p0[SYNC_STAGES-1];

  // A channel accepts its new level on the edge where the mismatch has
  // already persisted FILT_CYCLES-1 cycles and is still present.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync_last[i] != data_p1[i]) && (cnt_p1[i] == CNT_LAST);
    end
  end

  // ---- Stage 1: persistence filter ----
  // Any cycle that agrees with the current level clears the count, so a
  // mismatch never accumulates across interruptions.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_p1 <= {WIDTH{RST_VAL}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_last[i] == data_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (accept[i]) begin
          data_p1[i] <= sync_last[i];
          cnt_p1[i]  <= '0;
        end else begin
          cnt_p1[i] <= cnt_p1[i] + CNT_ONE;
        end
      end
    end
  end

  assign DATA_IN = data_p1;

`ifdef GTECH_INBUF_FILT_EDGE_EN
  logic [WIDTH-1:0] rise_p1;
  logic [WIDTH-1:0] fall_p1;

  // ---- Stage 1: edge pulses, registered alongside DATA_IN ----
  // Derived from the acceptance itself, so the pulse lands in the same
  // cycle DATA_IN first shows the new level and reset never produces one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rise_p1 <= '0;
      fall_p1 <= '0;
    end else begin
      rise_p1 <= accept & sync_last;
      fall_p1 <= accept & ~sync_last;
    end
  end

  assign RISE = rise_p1;
  assign FALL = fall_p1;
`else
  assign RISE = '0;
  assign FALL = '0;
`endif

endmodule
